// File: rtl/crc_mon_pkg.sv
// Shared types and constants for the CRC error monitor.
package crc_mon_pkg;

  typedef enum logic [1:0] {
    MON_OK    = 2'b00,
    MON_WARN  = 2'b01,
    MON_FAULT = 2'b10
  } mon_state_e;

  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_MEM1 = 2'b01;
  localparam logic [1:0] FS_MEM2 = 2'b10;
  localparam logic [1:0] FS_BOTH = 2'b11;

  localparam int CNT_W_DEF      = 8;
  localparam int WIN_CYCLES_DEF = 64;

endpackage

// File: rtl/crc_err_event.sv
// Per-memory event extraction: rising-edge detect, correctable/uncorrectable
// classification and two saturating counters with synchronous clear.
module crc_err_event
  import crc_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_i,
  input  logic             corr_i,
  input  logic             clr_i,
  output logic             corr_ev_o,
  output logic             uncorr_ev_o,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o
);

  logic             det_q;
  logic             ev;
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;

  assign ev          = det_i & ~det_q;
  assign corr_ev_o   = ev & corr_i;
  assign uncorr_ev_o = ev & ~corr_i;

  // Clear first, then apply this cycle's event on top of the cleared value.
  always_comb begin
    corr_d   = clr_i ? '0 : corr_q;
    uncorr_d = clr_i ? '0 : uncorr_q;
    if (corr_ev_o && (corr_d != '1))
      corr_d = corr_d + CNT_W'(1);
    if (uncorr_ev_o && (uncorr_d != '1))
      uncorr_d = uncorr_d + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q    <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      det_q    <= det_i;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;

endmodule

// File: rtl/crc_err_monitor.sv
// Safety monitor for two CRC-protected memories: event counters, windowed
// correctable-error rate and an OK/WARN/FAULT alarm FSM with irq and first-fault source.
module crc_err_monitor
  import crc_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_CYCLES = WIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem1_err_detected_i,
  input  logic             mem1_err_corrected_i,
  input  logic             mem2_err_detected_i,
  input  logic             mem2_err_corrected_i,
  input  logic [3:0]       cfg_thresh_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] mem1_corr_cnt_o,
  output logic [CNT_W-1:0] mem1_uncorr_cnt_o,
  output logic [CNT_W-1:0] mem2_corr_cnt_o,
  output logic [CNT_W-1:0] mem2_uncorr_cnt_o,
  output logic             alarm_warn_o,
  output logic             alarm_fault_o,
  output logic             irq_o,
  output logic [1:0]       first_src_o
);

  localparam int WIN_W = $clog2(WIN_CYCLES);

  logic c1, u1, c2, u2;

  crc_err_event #(.CNT_W(CNT_W)) u_mem1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .det_i        (mem1_err_detected_i),
    .corr_i       (mem1_err_corrected_i),
    .clr_i        (clr_i),
    .corr_ev_o    (c1),
    .uncorr_ev_o  (u1),
    .corr_cnt_o   (mem1_corr_cnt_o),
    .uncorr_cnt_o (mem1_uncorr_cnt_o)
  );

  crc_err_event #(.CNT_W(CNT_W)) u_mem2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .det_i        (mem2_err_detected_i),
    .corr_i       (mem2_err_corrected_i),
    .clr_i        (clr_i),
    .corr_ev_o    (c2),
    .uncorr_ev_o  (u2),
    .corr_cnt_o   (mem2_corr_cnt_o),
    .uncorr_cnt_o (mem2_uncorr_cnt_o)
  );

  logic [WIN_W-1:0] win_cnt_q;
  logic [3:0]       win_ev_q, win_ev_d, win_base;
  logic [1:0]       win_inc;
  logic [4:0]       win_sum;
  logic             rate_hit;

  // A new window starts on the cycle the free-running counter reads zero.
  always_comb begin
    win_inc  = {1'b0, c1} + {1'b0, c2};
    win_base = (clr_i || (win_cnt_q == '0)) ? 4'd0 : win_ev_q;
    win_sum  = {1'b0, win_base} + {3'b000, win_inc};
    win_ev_d = win_sum[4] ? 4'hF : win_sum[3:0];
    rate_hit = (cfg_thresh_i != 4'd0) && (win_ev_d >= cfg_thresh_i);
  end

  mon_state_e state_q, state_d, state_base;
  logic [1:0] first_src_q, first_src_d;
  logic       irq_d;

  always_comb begin
    state_base  = clr_i ? MON_OK : state_q;
    state_d     = state_base;
    first_src_d = clr_i ? FS_NONE : first_src_q;
    if ((state_base != MON_FAULT) && (u1 || u2 || rate_hit)) begin
      state_d     = MON_FAULT;
      first_src_d = FS_NONE;
      if (u1 || (rate_hit && c1)) first_src_d = first_src_d | FS_MEM1;
      if (u2 || (rate_hit && c2)) first_src_d = first_src_d | FS_MEM2;
    end else if ((state_base == MON_OK) && (c1 || c2)) begin
      state_d = MON_WARN;
    end
    irq_d = (state_d != state_base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q     <= '0;
      win_ev_q      <= 4'd0;
      state_q       <= MON_OK;
      first_src_q   <= FS_NONE;
      irq_o         <= 1'b0;
      alarm_warn_o  <= 1'b0;
      alarm_fault_o <= 1'b0;
    end else begin
      win_cnt_q     <= win_cnt_q + WIN_W'(1);
      win_ev_q      <= win_ev_d;
      state_q       <= state_d;
      first_src_q   <= first_src_d;
      irq_o         <= irq_d;
      alarm_warn_o  <= (state_d == MON_WARN);
      alarm_fault_o <= (state_d == MON_FAULT);
    end
  end

  assign first_src_o = first_src_q;

endmodule

// File: tb/tb_crc_err_monitor.sv
// Directed bench for crc_err_monitor with a behavioural reference model
// compared every cycle, plus hand-computed spot checks.
module tb_crc_err_monitor;

  localparam int CW = 3;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d1 = 0, c1 = 0, d2 = 0, c2 = 0, clr = 0;
  logic [3:0]    thresh = 4'd0;
  logic [CW-1:0] corr1, uncorr1, corr2, uncorr2;
  logic          warn, fault, irq;
  logic [1:0]    fsrc;

  crc_err_monitor #(.CNT_W(CW), .WIN_CYCLES(W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mem1_err_detected_i  (d1),
    .mem1_err_corrected_i (c1),
    .mem2_err_detected_i  (d2),
    .mem2_err_corrected_i (c2),
    .cfg_thresh_i         (thresh),
    .clr_i                (clr),
    .mem1_corr_cnt_o      (corr1),
    .mem1_uncorr_cnt_o    (uncorr1),
    .mem2_corr_cnt_o      (corr2),
    .mem2_uncorr_cnt_o    (uncorr2),
    .alarm_warn_o         (warn),
    .alarm_fault_o        (fault),
    .irq_o                (irq),
    .first_src_o          (fsrc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int irq_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, one update per clock edge.
  int m_c1, m_u1, m_c2, m_u2, m_state, m_fs, m_win, m_n;
  bit m_irq, p1, p2;
  localparam int SAT = (1 << CW) - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_c1 = 0; m_u1 = 0; m_c2 = 0; m_u2 = 0;
      m_state = 0; m_fs = 0; m_win = 0; m_n = 0;
      m_irq = 0; p1 = 0; p2 = 0;
    end else begin
      bit e1, e2, ce1, ue1, ce2, ue2, rate;
      int old;
      e1 = d1 && !p1;  e2 = d2 && !p2;
      ce1 = e1 && c1;  ue1 = e1 && !c1;
      ce2 = e2 && c2;  ue2 = e2 && !c2;
      if (clr) begin
        m_c1 = 0; m_u1 = 0; m_c2 = 0; m_u2 = 0;
        m_fs = 0; m_state = 0; m_win = 0;
      end
      if (ce1) m_c1 = (m_c1 < SAT) ? m_c1 + 1 : SAT;
      if (ue1) m_u1 = (m_u1 < SAT) ? m_u1 + 1 : SAT;
      if (ce2) m_c2 = (m_c2 < SAT) ? m_c2 + 1 : SAT;
      if (ue2) m_u2 = (m_u2 < SAT) ? m_u2 + 1 : SAT;
      if (m_n % W == 0) m_win = 0;
      m_win = m_win + int'(ce1) + int'(ce2);
      if (m_win > 15) m_win = 15;
      rate = (thresh != 0) && (m_win >= int'(thresh));
      old = m_state;
      if (m_state != 2 && (ue1 || ue2 || rate)) begin
        m_state = 2;
        m_fs = ((ue1 || (rate && ce1)) ? 1 : 0) + ((ue2 || (rate && ce2)) ? 2 : 0);
      end else if (m_state == 0 && (ce1 || ce2)) begin
        m_state = 1;
      end
      m_irq = (m_state != old);
      p1 = d1; p2 = d2;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("corr1", corr1, m_c1);
      chk("uncorr1", uncorr1, m_u1);
      chk("corr2", corr2, m_c2);
      chk("uncorr2", uncorr2, m_u2);
      chk("warn", warn, (m_state == 1) ? 1 : 0);
      chk("fault", fault, (m_state == 2) ? 1 : 0);
      chk("irq", irq, m_irq);
      chk("first_src", fsrc, m_fs);
    end
    if (rst_n && irq === 1'b1) irq_seen++;
  end

  task automatic cyc(input bit a, input bit b, input bit c, input bit d, input bit cl);
    d1 = a; c1 = b; d2 = c; c2 = d; clr = cl;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wait_win(input int off);
    for (int i = 0; i < W && (m_n % W) != off; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"}, {corr1, uncorr1, corr2, uncorr2}, 0);
    chk({tag, "_alarm"}, {warn, fault, irq}, 0);
    chk({tag, "_fsrc"}, fsrc, 0);
  endtask

  int base;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1;

    // single correctable event, level held 3 cycles
    base = irq_seen;
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    idle(2);
    chk("t1_corr1", corr1, 1);
    chk("t1_warn", warn, 1);
    chk("t1_fault", fault, 0);
    chk("t1_irq_pulses", irq_seen - base, 1);

    // uncorrectable on MEM2 escalates WARN -> FAULT
    cyc(0, 0, 1, 0, 0);
    idle(1);
    chk("t2_uncorr2", uncorr2, 1);
    chk("t2_fault", fault, 1);
    chk("t2_warn", warn, 0);
    chk("t2_fsrc", fsrc, 2);
    chk("t2_irq_pulses", irq_seen - base, 2);

    // rate threshold: four events in one window
    cyc(0, 0, 0, 0, 1);
    thresh = 4'd4;
    wait_win(2);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (i == 2) chk("t3_fault_after3", fault, 0);
      if (i == 3) chk("t3_fault_after4", fault, 1);
      idle(4);
    end
    chk("t3_fsrc", fsrc, 1);
    chk("t3_corr1", corr1, 4);

    // same four events straddling a window boundary
    cyc(0, 0, 0, 0, 1);
    wait_win(54);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0);
      idle(4);
    end
    chk("t3s_warn", warn, 1);
    chk("t3s_fault", fault, 0);
    chk("t3s_corr1", corr1, 4);

    // simultaneous uncorrectable from OK
    thresh = 4'd0;
    cyc(0, 0, 0, 0, 1);
    base = irq_seen;
    cyc(1, 0, 1, 0, 0);
    idle(2);
    chk("t4_uncorr", {uncorr1, uncorr2}, {3'd1, 3'd1});
    chk("t4_fsrc", fsrc, 3);
    chk("t4_irq_pulses", irq_seen - base, 1);

    // saturation at 7 with CNT_W=3
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("t5_sat", corr1, 7);
    chk("t5_warn", warn, 1);

    // clr coincident with MEM1 uncorrectable
    base = irq_seen;
    cyc(1, 0, 0, 0, 1);
    chk("t6_uncorr1", uncorr1, 1);
    chk("t6_corr1", corr1, 0);
    chk("t6_fault", fault, 1);
    chk("t6_fsrc", fsrc, 1);
    chk("t6_irq_pulses", irq_seen - base, 1);
    idle(1);

    // async reset mid-FAULT, input already high at release
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    d1 = 1; c1 = 1;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t7_corr1", corr1, 1);
    chk("t7_warn", warn, 1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
